ether_rx: RTL
=============

Name: ether_rx

Overview:
- RMII receive front-end that sits directly upstream of the MAC firewall stage.
- Samples the PHY's CRS_DV/RXD dibit stream and hunts for the Ethernet preamble and SFD.
- Strips both, then streams the frame dibits (destination MAC onward, FCS included) on the axiod/axiov interface the firewall consumes.
- Reports frame completion, byte length and framing errors.

Parameters:
- MIN_PREAMBLE, 28: minimum count of consecutive 2'b01 dibits required before the SFD terminator 2'b11 is accepted. The nominal count is 31; the slack tolerates PHY start-up loss.
- MAX_DIBITS, 6144: maximum payload dibits per frame (1536 bytes). Exceeding it aborts the frame.

Ports:
- clk  input  1  50 MHz RMII reference clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- crsdv_in  input  1  PHY carrier-sense/data-valid.
- rxd_in  input  2  PHY receive dibit, LSB-first bit order.
- axiov  output  1  stripped frame dibit valid.
- axiod  output  2  stripped frame dibit, passed through in arrival order unmodified.
- frame_done  output  1  one-cycle pulse when a frame in DATA ends.
- frame_len  output  11  byte count of the last completed frame; held until the next frame_done.
- err  output  1  one-cycle pulse on any framing error.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0 immediately: axiov, axiod, frame_done, frame_len, err.
  - FSM goes to IDLE; counters clear; input registers clear.
  - Reset mid-frame discards the frame with no frame_done and no err.
- Input pipeline: crsdv_in/rxd_in are registered once (r_dv, r_d). The FSM acts on r_dv/r_d and all outputs are registered.
- Latency: a dibit present before clock edge k appears on axiod with axiov=1 after edge k+1, i.e. a fixed 2-cycle latency with no bubbles.
- Preamble counter: saturates at MIN_PREAMBLE. Data counter is 13 bits and saturates at MAX_DIBITS+1.
- FSM states IDLE, PREAMBLE, DATA, ABORT. Transitions are evaluated each cycle on r_dv/r_d:
  - IDLE:
    - r_dv=1 and r_d=01 -> PREAMBLE, pcount=1.
    - Any other r_dv=1 dibit -> ABORT with err pulse.
    - r_dv=0 -> stay.
  - PREAMBLE:
    - r_dv=0 -> IDLE, silently (no err, no frame_done).
    - r_d=01 -> pcount++.
    - r_d=11 with pcount>=MIN_PREAMBLE -> DATA, dcount=0.
    - r_d=11 with pcount<MIN_PREAMBLE -> ABORT + err.
    - r_d=00 or 10 -> ABORT + err.
  - DATA:
    - r_dv=1 -> axiov=1, axiod=r_d, dcount++.
    - dcount reaching MAX_DIBITS+1 -> axiov=0 that cycle, ABORT + err, no frame_done.
    - r_dv=0 -> axiov=0, frame_done=1, frame_len=dcount>>2, then IDLE. If dcount[1:0]!=0, err=1 in the same cycle (misaligned frame); frame_len is still the truncated value.
  - ABORT: axiov=0; wait for r_dv=0, then IDLE. No further err pulses in ABORT.
- SFD immediately followed by carrier drop: frame_done=1, frame_len=0, err=0.
- A new frame is accepted the cycle after returning to IDLE. Back-to-back frames need at least one r_dv=0 cycle between them.
- axiod holds its last value while axiov=0. Consumers must qualify it with axiov.
- err and frame_done never assert outside the cases listed above.

Test Plan:
- Nominal frame: 31x dibit 01, then 11, then 24 dibits of 11 (6x FF broadcast dest), 24 dibits of 00, 8 dibits of 10, then crsdv low -> axiov high for exactly 56 cycles starting 2 cycles after the first post-SFD dibit; axiod stream matches input; frame_done pulse; frame_len=14; err=0.
- Short preamble: 10x 01 then 11 -> err pulse, axiov never asserts, FSM waits for crsdv low. A following nominal frame is received correctly.
- Bad preamble dibit: 20x 01, then 00 -> err; 30x 01 with crsdv dropped -> IDLE, err=0, frame_done=0.
- Misaligned/empty frames:
  - 30 data dibits -> frame_done, frame_len=7, err=1 same cycle.
  - SFD then immediate crsdv low -> frame_done, frame_len=0, err=0.
- Oversize: MAX_DIBITS+5 data dibits -> axiov drops after exactly MAX_DIBITS valid cycles, err pulses once, no frame_done, frame_len keeps its previous value.
- Async reset mid-DATA: assert rst between clock edges after 40 data dibits -> axiov/axiod/frame_done/err go to 0 without waiting for a clock edge, frame_len=0. Release and send a nominal frame -> received with frame_len=14.

Source files
------------

// File: rtl/ether_rx.sv
// rtl/ether_rx.sv - RMII receive front-end: preamble/SFD hunt, strip, stream frame dibits
// Reports frame completion, byte length and framing errors with a fixed 2-cycle data latency.
module ether_rx #(
  parameter int MIN_PREAMBLE = 28,
  parameter int MAX_DIBITS   = 6144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv_in,
  input  logic [1:0]  rxd_in,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic        err
);

  localparam int PW = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PW-1:0] PMAX = PW'(MIN_PREAMBLE);
  localparam logic [12:0]   DMAX = 13'(MAX_DIBITS + 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, ABORT} state_t;

  state_t        state, state_nxt;
  logic          r_dv;
  logic [1:0]    r_d;
  logic [PW-1:0] pcount, pcount_nxt;
  logic [12:0]   dcount, dcount_nxt, dcount_inc;
  logic          axiov_nxt, frame_done_nxt, err_nxt;
  logic [1:0]    axiod_nxt;
  logic [10:0]   frame_len_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dv       <= 1'b0;
      r_d        <= 2'b00;
      state      <= IDLE;
      pcount     <= '0;
      dcount     <= '0;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      frame_done <= 1'b0;
      frame_len  <= '0;
      err        <= 1'b0;
    end else begin
      r_dv       <= crsdv_in;
      r_d        <= rxd_in;
      state      <= state_nxt;
      pcount     <= pcount_nxt;
      dcount     <= dcount_nxt;
      axiov      <= axiov_nxt;
      axiod      <= axiod_nxt;
      frame_done <= frame_done_nxt;
      frame_len  <= frame_len_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pcount_nxt     = pcount;
    dcount_nxt     = dcount;
    dcount_inc     = dcount + 13'd1;
    axiov_nxt      = 1'b0;
    axiod_nxt      = axiod;
    frame_done_nxt = 1'b0;
    frame_len_nxt  = frame_len;
    err_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (r_dv) begin
          if (r_d == 2'b01) begin
            state_nxt  = PREAMBLE;
            pcount_nxt = PW'(1);
          end else begin
            state_nxt = ABORT;
            err_nxt   = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (!r_dv) begin
          state_nxt = IDLE;
        end else begin
          case (r_d)
            2'b01: pcount_nxt = (pcount == PMAX) ? pcount : pcount + PW'(1);
            2'b11: begin
              if (pcount >= PMAX) begin
                state_nxt  = DATA;
                dcount_nxt = '0;
              end else begin
                state_nxt = ABORT;
                err_nxt   = 1'b1;
              end
            end
            default: begin
              state_nxt = ABORT;
              err_nxt   = 1'b1;
            end
          endcase
        end
      end
      DATA: begin
        if (r_dv) begin
          // The dibit that would exceed the limit is swallowed, not forwarded.
          if (dcount_inc == DMAX) begin
            dcount_nxt = DMAX;
            state_nxt  = ABORT;
            err_nxt    = 1'b1;
          end else begin
            dcount_nxt = dcount_inc;
            axiov_nxt  = 1'b1;
            axiod_nxt  = r_d;
          end
        end else begin
          frame_done_nxt = 1'b1;
          frame_len_nxt  = dcount[12:2];
          err_nxt        = |dcount[1:0];
          state_nxt      = IDLE;
        end
      end
      ABORT: begin
        if (!r_dv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
